// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam logic [3:0] PAT_1011 = 4'b1011;
  localparam logic [3:0] PAT_0000 = 4'b0000;

  localparam int CNT_W_DEF = 8;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

  // Width that can hold every fill level 0..n inclusive.
  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_detector_shift_window.sv
// N-bit serial shift window plus a saturating count of valid bits it holds.
module shift_window
  import seq_det_pkg::*;
#(
  parameter int N = 4,
  localparam int FW = fill_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          restart,
  input  logic          x,
  output logic [N-1:0]  q,
  output logic [N-1:0]  q_next,
  output logic [FW-1:0] fill_next
);

  localparam logic [FW-1:0] FILL_FULL = FW'(N);

  logic [N-1:0]  q_reg;
  logic [N-1:0]  shifted;
  logic [FW-1:0] fill_reg;

  assign shifted[0] = x;
  for (genvar gi = 1; gi < N; gi++) begin : g_shift
    assign shifted[gi] = q_reg[gi-1];
  end

  always_comb begin
    q_next    = q_reg;
    fill_next = fill_reg;
    if (en) begin
      q_next    = shifted;
      fill_next = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + 1'b1;
    end
  end

  // restart empties the fill count only; q still loads so matched bits stay visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_reg    <= '0;
      fill_reg <= '0;
    end else begin
      q_reg    <= q_next;
      fill_reg <= restart ? '0 : fill_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: compares the next window against PATTERN, registers y, counts matches.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = PAT_1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             clr_cnt,
  output logic             y,
  output logic [N-1:0]     q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FW = fill_w(N);
  localparam logic [FW-1:0]    FILL_FULL = FW'(N);
  localparam logic [CNT_W-1:0] CNT_ALL   = {CNT_W{1'b1}};

  logic [N-1:0]     q_next;
  logic [FW-1:0]    fill_next;
  logic             match;
  logic             y_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_reg;

  // The fill guard keeps reset zeros from matching patterns with leading zeros.
  assign match = en && (q_next == PATTERN) && (fill_next == FILL_FULL);

  shift_window #(.N(N)) u_window (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .restart   (match && !OVERLAP),
    .x         (x),
    .q         (q),
    .q_next    (q_next),
    .fill_next (fill_next)
  );

  always_comb begin
    cnt_next = cnt_reg;
    if (clr_cnt) begin
      cnt_next = match ? CNT_W'(1) : '0;
    end else if (match && (cnt_reg != CNT_ALL)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      y_reg   <= 1'b0;
      cnt_reg <= '0;
      sat_reg <= 1'b0;
    end else begin
      y_reg   <= match;
      cnt_reg <= cnt_next;
      sat_reg <= (cnt_next == CNT_ALL);
    end
  end

  assign y         = y_reg;
  assign match_cnt = cnt_reg;
  assign cnt_sat   = sat_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Drives four detector variants from one stimulus stream and checks them against a stream model.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic x = 1'b0;
  logic clr_cnt = 1'b0;

  logic       yv[4];
  logic [3:0] qv[4];
  logic [7:0] cv[3];
  logic [1:0] c3;
  logic       sv[4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // d0: 1011 overlap; d1: 1011 non-overlap; d2: 0000 overlap; d3: 1011 overlap, 2-bit counter
  seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) d0 (
    .clk(clk), .reset(reset), .en(en), .x(x), .clr_cnt(clr_cnt),
    .y(yv[0]), .q(qv[0]), .match_cnt(cv[0]), .cnt_sat(sv[0]));
  seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) d1 (
    .clk(clk), .reset(reset), .en(en), .x(x), .clr_cnt(clr_cnt),
    .y(yv[1]), .q(qv[1]), .match_cnt(cv[1]), .cnt_sat(sv[1]));
  seq_detector_param #(.N(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8)) d2 (
    .clk(clk), .reset(reset), .en(en), .x(x), .clr_cnt(clr_cnt),
    .y(yv[2]), .q(qv[2]), .match_cnt(cv[2]), .cnt_sat(sv[2]));
  seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) d3 (
    .clk(clk), .reset(reset), .en(en), .x(x), .clr_cnt(clr_cnt),
    .y(yv[3]), .q(qv[3]), .match_cnt(c3), .cnt_sat(sv[3]));

  // Reference model: bits accepted since reset, and per-variant bits since the last restart.
  int pat[4]  = '{4'b1011, 4'b1011, 4'b0000, 4'b1011};
  bit ovl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
  int cmax[4] = '{255, 255, 255, 3};
  bit stream[$];
  int since[4];
  int m_y[4];
  int m_cnt[4];
  int m_q;

  function automatic int window_val();
    int v = 0;
    foreach (stream[k]) v = (v << 1) | int'(stream[k]);
    return v;
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit xx, input bit c);
    if (!r) begin
      stream.delete();
      for (int i = 0; i < 4; i++) begin
        since[i] = 0; m_y[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      if (e) begin
        stream.push_back(xx);
        if (stream.size() > 4) void'(stream.pop_front());
      end
      for (int i = 0; i < 4; i++) begin
        bit hit = 1'b0;
        if (e) begin
          since[i]++;
          hit = (since[i] >= 4) && (window_val() == pat[i]);
          if (hit && !ovl[i]) since[i] = 0;
        end
        m_y[i] = int'(hit);
        if (c) m_cnt[i] = hit ? 1 : 0;
        else if (hit && m_cnt[i] < cmax[i]) m_cnt[i]++;
      end
    end
    m_q = window_val();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int cnt_of(input int i);
    if (i == 3) return int'(c3);
    return int'(cv[i]);
  endfunction

  // One clock: drive, update model on the edge, compare every variant 1 time unit later.
  task automatic step(input bit r, input bit e, input bit xx, input bit c);
    reset = r; en = e; x = xx; clr_cnt = c;
    @(posedge clk);
    model_edge(r, e, xx, c);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model_y_d%0d", i), int'(yv[i]), m_y[i]);
      chk($sformatf("model_q_d%0d", i), int'(qv[i]), m_q);
      chk($sformatf("model_cnt_d%0d", i), cnt_of(i), m_cnt[i]);
      chk($sformatf("model_sat_d%0d", i), int'(sv[i]), int'(m_cnt[i] == cmax[i]));
    end
  endtask

  typedef struct {
    bit r; bit e; bit x; bit c;
    bit ey0; logic [3:0] eq0; int ec0;
    bit ey1; int ec1;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 0, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 0, 1'b0, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0101, 0, 1'b0, 0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011, 1, 1'b1, 1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 1, 1'b0, 1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1101, 1, 1'b0, 1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011, 2, 1'b0, 1};

    // Reset, first match, overlap vs non-overlap
    for (int k = 0; k < 9; k++) begin
      step(tbl[k].r, tbl[k].e, tbl[k].x, tbl[k].c);
      chk($sformatf("tbl%0d_y0", k), int'(yv[0]), int'(tbl[k].ey0));
      chk($sformatf("tbl%0d_q0", k), int'(qv[0]), int'(tbl[k].eq0));
      chk($sformatf("tbl%0d_cnt0", k), int'(cv[0]), tbl[k].ec0);
      chk($sformatf("tbl%0d_sat0", k), int'(sv[0]), 0);
      chk($sformatf("tbl%0d_y1", k), int'(yv[1]), int'(tbl[k].ey1));
      chk($sformatf("tbl%0d_cnt1", k), int'(cv[1]), tbl[k].ec1);
      $display("[TB] vector %0d r=%0b en=%0b x=%0b -> y0=%0b q0=%b cnt0=%0d y1=%0b cnt1=%0d",
               k, tbl[k].r, tbl[k].e, tbl[k].x, yv[0], qv[0], cv[0], yv[1], cv[1]);
    end

    // Fill guard with an all-zero pattern
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("fill_guard_y2_edge%0d", k), int'(yv[2]), int'(k >= 4));
      $display("[TB] fill guard edge %0d y2=%0b", k, yv[2]);
    end

    // Enable gating
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("hold_y0", int'(yv[0]), 0);
      chk("hold_q0", int'(qv[0]), 4'b0010);
      $display("[TB] hold cycle %0d q0=%b y0=%0b", k, qv[0], yv[0]);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("resume_y0_first", int'(yv[0]), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("resume_y0", int'(yv[0]), 1);
    chk("resume_q0", int'(qv[0]), 4'b1011);
    $display("[TB] resume q0=%b y0=%0b", qv[0], yv[0]);

    // Saturation on the 2-bit counter, then clears
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int m = 1; m <= 4; m++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk($sformatf("sat_cnt3_match%0d", m), int'(c3), (m < 3) ? m : 3);
      chk($sformatf("sat_flag3_match%0d", m), int'(sv[3]), int'(m >= 3));
      $display("[TB] match %0d cnt3=%0d sat3=%0b", m, c3, sv[3]);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_cnt3", int'(c3), 0);
    chk("clr_sat3", int'(sv[3]), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_with_match_cnt3", int'(c3), 1);
    chk("clr_with_match_y3", int'(yv[3]), 1);
    $display("[TB] clear with match cnt3=%0d", c3);

    // Reset in the middle of a pattern
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("midreset_y0", int'(yv[0]), 0);
    chk("midreset_q0", int'(qv[0]), 4'b0001);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("midreset_y0_third", int'(yv[0]), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("midreset_y0_match", int'(yv[0]), 1);
    $display("[TB] mid-reset recovery q0=%b y0=%0b", qv[0], yv[0]);

    // Random traffic against the model
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    $display("[TB] random phase done, y0=%0b cnt0=%0d cnt3=%0d", yv[0], cv[0], c3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the team's single-bit flip-flop circuit (clk, x, reset → y, q).
- Shifts serial input x into an N-bit window q on each enabled clock.
- Asserts y when the window holds a programmable PATTERN, with overlapping or non-overlapping detection.
- Keeps a saturating count of matches for status/debug logic above it.

Parameters:
- N, 4, pattern/window length in bits; legal range 2..16.
- PATTERN, 4'b1011, N-bit target sequence; bit N-1 is the oldest bit, bit 0 the newest.
- OVERLAP, 1, 1 = bits of a match may start the next match; 0 = window restarts after each match.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 at posedge = reset).
- en  input  1  shift enable; x is sampled only when en=1.
- x  input  1  serial data bit.
- clr_cnt  input  1  synchronous clear of match_cnt and cnt_sat.
- y  output  1  registered match pulse.
- q  output  N  current window contents.
- match_cnt  output  CNT_W  saturating count of matches.
- cnt_sat  output  1  high while match_cnt is all-ones.

Behaviour:
- Reset: reset=0 at posedge sets q=0, fill=0, y=0, match_cnt=0, cnt_sat=0. Reset overrides en and clr_cnt. There is no asynchronous path.
- Internal fill counter: width $clog2(N+1); counts valid bits in the window and saturates at N.
- Shift (en=1): q_next = {q[N-2:0], x}; fill_next = min(fill+1, N).
- Match condition: match = en && (q_next == PATTERN) && (fill_next == N).
  - The fill guard prevents reset zeros from matching a PATTERN that contains leading zeros.
- y timing: y <= match, registered on the same edge that loads q_next.
  - y is visible in the cycle after x was presented.
  - y is a one-cycle pulse per match.
- OVERLAP=0: on a match, fill <= 0; q still loads q_next so the matched bits stay observable.
- OVERLAP=1: fill stays at N after a match, so back-to-back matches are possible.
- Hold (en=0): q and fill hold; y <= 0.
- Counter, evaluated at each posedge with reset=1:
  - clr_cnt=1 and match=0: match_cnt=0.
  - clr_cnt=1 and match=1: match_cnt=1 (the clear and the new match are both honoured).
  - clr_cnt=0 and match=1: match_cnt increments unless already all-ones.
  - cnt_sat = (match_cnt_next == all-ones).
- Reset mid-pattern: any partial sequence is discarded; a match needs N fresh enabled bits after reset.
- x and en are synchronous inputs and are assumed stable around the clock edge.

Decomposition:
- Package seq_det_pkg holds:
  - default PATTERN constants (e.g. PAT_1011, PAT_0000);
  - a fill_w(N) function returning $clog2(N+1);
  - localparam CNT_MAX helper.
- Sub-module shift_window(N): shift register plus fill counter with en, restart and reset. Outputs q_next, fill_next and q.
- Top level adds pattern compare, the y register and the match counter.

Test Plan:
Unless stated, all scenarios use N=4, PATTERN=4'b1011, en=1 throughout.
- Reset: reset=0 for 2 edges while x toggles → q=0, y=0, match_cnt=0, cnt_sat=0. Release, then drive x=1,0,1,1 → y=1 only after the 4th edge, q=4'b1011, match_cnt=1.
- Overlap: OVERLAP=1, x=1,0,1,1,0,1,1 → y high after edges 4 and 7, match_cnt=2. Same stimulus with OVERLAP=0 → y only after edge 4, match_cnt=1.
- Fill guard: PATTERN=4'b0000, reset released, then x=0 every cycle → y stays 0 after edges 1–3. With OVERLAP=1, y=1 after edge 4 and stays high every following edge.
- En gating: x=1,0 (en=1), then en=0 for 3 cycles with x=1, then en=1 with x=1,1 → y=0 during the hold and y=1 after the final edge. q holds 4'b0010 (fill=2) while en=0, then reads 4'b1011.
- Saturation and clear: CNT_W=2, 4 separate matches → match_cnt=3 and cnt_sat=1 after the 3rd match, unchanged after the 4th. clr_cnt=1 → match_cnt=0, cnt_sat=0. clr_cnt=1 on the same edge as a match → match_cnt=1.
- Reset mid-operation: x=1,0,1, then reset=0 for 1 edge, then x=1 → y=0 and q=4'b0001. Then x=0,1,1 → y=1 after the 4th post-reset bit.
